multiplier_controller: RTL

MULTIPLIER_CONTROLLER -- requirements
Module: multiplier_controller

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_step_counter.sv | 33 +++
 rtl/multiplier_controller.sv | 79 +++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
package mult_pkg;
   localparam int WIDTH_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TEST,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_e;
endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the multiplier controller: counts completed SHIFT steps
// and flags the last one. Counter is one bit wider than needed so it can
// never wrap inside an operation.
module mult_step_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_CLR,
   input  logic i_INC,
   output logic o_TC
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (i_CLR)      cnt_d = '0;
      else if (i_INC) cnt_d = cnt_q + CW'(1);
   end

   // count register with synchronous reset
   always_ff @(posedge i_CLK) begin
      if (i_RESET) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign o_TC = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/multiplier_controller.sv
// Moore FSM sequencing a shift-add multiplier datapath: LOAD, then WIDTH
// rounds of TEST -> (ADD) -> SHIFT, then a one-cycle DONE pulse.
// Optional feature: define MULT_CTRL_ABORT_EN to add the i_ABORT input,
// which returns any busy state to IDLE without a DONE pulse.
module multiplier_controller
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_START,
   input  logic i_LSB,
`ifdef MULT_CTRL_ABORT_EN
   input  logic i_ABORT,
`endif
   output logic o_LOAD_cmd,
   output logic o_ADD_cmd,
   output logic o_SHIFT_cmd,
   output logic o_BUSY,
   output logic o_DONE
);
   state_e state_q, state_d;
   logic   last_step;
   logic   cnt_clr, cnt_inc;

   // counter is cleared on entry work (LOAD) and steps on every SHIFT except the last
   assign cnt_clr = (state_q == S_LOAD);
   assign cnt_inc = (state_q == S_SHIFT) && !last_step;

   mult_step_counter #(.WIDTH(WIDTH)) u_cnt (
      .i_CLK   (i_CLK),
      .i_RESET (i_RESET),
      .i_CLR   (cnt_clr),
      .i_INC   (cnt_inc),
      .o_TC    (last_step)
   );

   // state register with synchronous reset
   always_ff @(posedge i_CLK) begin
      if (i_RESET) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_START) state_d = S_LOAD;
         S_LOAD:  state_d = S_TEST;
         S_TEST:  state_d = i_LSB ? S_ADD : S_SHIFT;
         S_ADD:   state_d = S_SHIFT;
         S_SHIFT: state_d = last_step ? S_DONE : S_TEST;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef MULT_CTRL_ABORT_EN
      if (i_ABORT && (state_q inside {S_LOAD, S_TEST, S_ADD, S_SHIFT}))
         state_d = S_IDLE;
`endif
   end

   // outputs decoded from the state register only
   always_comb begin
      o_LOAD_cmd  = 1'b0;
      o_ADD_cmd   = 1'b0;
      o_SHIFT_cmd = 1'b0;
      o_BUSY      = 1'b0;
      o_DONE      = 1'b0;
      case (state_q)
         S_LOAD:  begin o_LOAD_cmd  = 1'b1; o_BUSY = 1'b1; end
         S_TEST:  o_BUSY = 1'b1;
         S_ADD:   begin o_ADD_cmd   = 1'b1; o_BUSY = 1'b1; end
         S_SHIFT: begin o_SHIFT_cmd = 1'b1; o_BUSY = 1'b1; end
         S_DONE:  o_DONE = 1'b1;
         default: ;
      endcase
   end
endmodule
